// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stable-count
// debounce, and registered press / release / auto-repeat hold pulses per channel.
module btn_debounce #(
    parameter int NUM_BTN    = 4,
    parameter int CNT_MAX    = 500000,
    parameter int HOLD_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int HMAX  = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int HW    = $clog2(HMAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(CNT_MAX - 1);
    localparam logic [HW-1:0]    HOLD_ZERO = HW'(0);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]    HOLD_LIM  = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0]    REP_LIM   = HW'((REPEAT_CYC > 0) ? (REPEAT_CYC - 1) : 0);
    localparam bit               REP_EN    = (REPEAT_CYC > 0);

    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] press_s;
    logic [NUM_BTN-1:0] release_s;
    logic [NUM_BTN-1:0] hold_s;

    // Two-flop synchroniser for the asynchronous panel inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {NUM_BTN{1'b0}};
            sync2_r <= {NUM_BTN{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic             deb_r;
        logic             deb_s;
        logic [CNT_W-1:0] deb_cnt_r;
        logic [CNT_W-1:0] deb_cnt_s;
        logic [HW-1:0]    hold_cnt_r;
        logic [HW-1:0]    hold_cnt_s;
        logic             rep_phase_r;
        logic             rep_phase_s;
        logic             hold_evt_s;

        // Debounce: accept the synchronised level after CNT_MAX consecutive differing samples
        always_comb begin
            deb_s     = deb_r;
            deb_cnt_s = CNT_ZERO;
            if (sync2_r[i] == deb_r) begin
                deb_s     = deb_r;
                deb_cnt_s = CNT_ZERO;
            end else if (deb_cnt_r == CNT_LIM) begin
                deb_s     = ~deb_r;
                deb_cnt_s = CNT_ZERO;
            end else begin
                deb_s     = deb_r;
                deb_cnt_s = deb_cnt_r + CNT_ONE;
            end
        end

        // Hold timing: first pulse HOLD_CYC after the press edge, then every REPEAT_CYC.
        // btn_level still low while deb_r is high marks the press edge itself.
        always_comb begin
            hold_cnt_s  = hold_cnt_r;
            rep_phase_s = rep_phase_r;
            hold_evt_s  = 1'b0;
            if (!deb_r) begin
                hold_cnt_s  = HOLD_ZERO;
                rep_phase_s = 1'b0;
            end else if (!btn_level[i]) begin
                hold_cnt_s  = HOLD_ZERO;
                rep_phase_s = 1'b0;
            end else if (!rep_phase_r) begin
                if (hold_cnt_r == HOLD_LIM) begin
                    hold_evt_s  = 1'b1;
                    hold_cnt_s  = HOLD_ZERO;
                    rep_phase_s = 1'b1;
                end else begin
                    hold_cnt_s  = hold_cnt_r + HOLD_ONE;
                end
            end else if (!REP_EN) begin
                hold_cnt_s = hold_cnt_r;
            end else if (hold_cnt_r == REP_LIM) begin
                hold_evt_s = 1'b1;
                hold_cnt_s = HOLD_ZERO;
            end else begin
                hold_cnt_s = hold_cnt_r + HOLD_ONE;
            end
        end

        // Per-channel debounce and hold state
        always_ff @(posedge clk) begin
            if (rst) begin
                deb_r       <= 1'b0;
                deb_cnt_r   <= CNT_ZERO;
                hold_cnt_r  <= HOLD_ZERO;
                rep_phase_r <= 1'b0;
            end else begin
                deb_r       <= deb_s;
                deb_cnt_r   <= deb_cnt_s;
                hold_cnt_r  <= hold_cnt_s;
                rep_phase_r <= rep_phase_s;
            end
        end

        assign level_s[i]   = deb_r;
        assign press_s[i]   = deb_r & ~btn_level[i];
        assign release_s[i] = ~deb_r & btn_level[i];
        assign hold_s[i]    = hold_evt_s;
    end

    // Registered outputs; btn_level doubles as the edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= {NUM_BTN{1'b0}};
            btn_press   <= {NUM_BTN{1'b0}};
            btn_release <= {NUM_BTN{1'b0}};
            btn_hold    <= {NUM_BTN{1'b0}};
        end else begin
            btn_level   <= level_s;
            btn_press   <= press_s;
            btn_release <= release_s;
            btn_hold    <= hold_s;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised scoreboard bench for btn_debounce: a sliding-window reference model
// predicts every cycle's outputs; directed scenarios add fixed-edge spot checks.
module tb_btn_debounce;

    localparam int NB   = 4;
    localparam int CM   = 4;
    localparam int HC   = 10;
    localparam int RC   = 5;
    localparam int MAXE = 8000;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] a_level, a_press, a_release, a_hold;
    logic [NB-1:0] b_level, b_press, b_release, b_hold;

    always #5 clk = ~clk;

    btn_debounce #(.NUM_BTN(NB), .CNT_MAX(CM), .HOLD_CYC(HC), .REPEAT_CYC(RC)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(a_level), .btn_press(a_press), .btn_release(a_release), .btn_hold(a_hold)
    );

    btn_debounce #(.NUM_BTN(NB), .CNT_MAX(CM), .HOLD_CYC(HC), .REPEAT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(b_level), .btn_press(b_press), .btn_release(b_release), .btn_hold(b_hold)
    );

    typedef struct {
        int            e;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] hld_a;
        logic [NB-1:0] hld_b;
    } exp_t;

    exp_t sb_q[$];
    int   g       = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   base    = 0;

    task automatic check_w(input string name, input logic [4*NB-1:0] act, input logic [4*NB-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, g);
        end
    endtask

    task automatic check4(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b (edge %0d, rel %0d)", name, act, exp, g, g - base - 1);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model state: input history, accepted level history, press bookkeeping
    logic [NB-1:0] raw_h [MAXE];
    logic [NB-1:0] lev_h [MAXE];
    int            last_rst;
    int            last_tog [NB];
    bit            lvl_o [NB];
    bit            valid [NB];
    int            p_edge [NB];

    // A level is accepted at edge t when the CM synchronised samples seen at edges
    // t-CM+1..t all differ from it and none predates the last reset or acceptance.
    task automatic model_step(input int t);
        exp_t x;
        bit   lp, s, tog;
        int   u, d;
        x.e = t; x.lvl = '0; x.prs = '0; x.rel = '0; x.hld_a = '0; x.hld_b = '0;
        raw_h[t] = btn_raw;
        lev_h[t] = '0;
        if (rst) begin
            last_rst = t;
            for (int ch = 0; ch < NB; ch++) begin
                last_tog[ch] = t; lvl_o[ch] = 1'b0; valid[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < NB; ch++) begin
                lp  = (t > 1) ? lev_h[t-1][ch] : 1'b0;
                tog = 1'b1;
                for (int k = 0; k < CM; k++) begin
                    u = t - k;
                    if (u <= last_tog[ch]) tog = 1'b0;
                    else begin
                        s = (u - 2 > last_rst && u - 2 >= 1) ? raw_h[u-2][ch] : 1'b0;
                        if (s == lp) tog = 1'b0;
                    end
                end
                lev_h[t][ch] = tog ? ~lp : lp;
                if (tog) last_tog[ch] = t;
                x.lvl[ch] = lp;
                x.prs[ch] = lp & ~lvl_o[ch];
                x.rel[ch] = ~lp & lvl_o[ch];
                lvl_o[ch] = lp;
                if (!lp) valid[ch] = 1'b0;
                if (x.prs[ch]) begin
                    valid[ch] = 1'b1; p_edge[ch] = t;
                end else if (valid[ch]) begin
                    d = t - p_edge[ch];
                    x.hld_a[ch] = (d == HC) || (d > HC && ((d - HC) % RC) == 0);
                    x.hld_b[ch] = (d == HC);
                end
            end
        end
        sb_q.push_back(x);
    endtask

    initial begin : model
        last_rst = -100;
        for (int ch = 0; ch < NB; ch++) begin
            last_tog[ch] = -100; lvl_o[ch] = 1'b0; valid[ch] = 1'b0; p_edge[ch] = 0;
        end
        forever begin
            @(posedge clk);
            g++;
            if (g < MAXE) model_step(g);
        end
    end

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check_w("sb_dut_a", {a_level, a_press, a_release, a_hold}, {x.lvl, x.prs, x.rel, x.hld_a});
                check_w("sb_dut_b", {b_level, b_press, b_release, b_hold}, {x.lvl, x.prs, x.rel, x.hld_b});
            end
        end
    end

    task automatic start();
        base = g;
    endtask

    task automatic goto(input int k);
        while (g < base + 1 + k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_raw = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (CM + 3) @(negedge clk);
    endtask

    initial begin : stimulus
        int nh_a, nh_b, he_b;
        int seg [NB];
        rst = 1'b1; btn_raw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check4("reset_level", a_level, 4'b0000);

        // Clean press on channel 0
        do_reset(); btn_raw = 4'b0001; start();
        goto(5); check4("t1_level_e5", a_level, 4'b0000);
        goto(6); check4("t1_level_e6", a_level, 4'b0001); check4("t1_press_e6", a_press, 4'b0001);
        goto(7); check4("t1_press_e7", a_press, 4'b0000);

        // Bounce on channel 1: 2-cycle segments, final rise reaches edge 8
        do_reset(); btn_raw[1] = 1'b1; start();
        for (int k = 0; k < 14; k++) begin
            goto(k);
            check4("t2_no_press", a_press, 4'b0000);
            if (k == 1 || k == 5) btn_raw[1] = 1'b0;
            else if (k == 3 || k == 7) btn_raw[1] = 1'b1;
        end
        goto(14); check4("t2_press_e14", a_press, 4'b0010);
        goto(15); check4("t2_press_e15", a_press, 4'b0000);

        // Hold and repeat on channel 2, release reaching edge 24
        do_reset(); btn_raw[2] = 1'b1; start();
        goto(6);  check4("t3_press_e6", a_press, 4'b0100);
        goto(15); check4("t3_hold_e15", a_hold, 4'b0000);
        goto(16); check4("t3_hold_e16", a_hold, 4'b0100); check4("t3_bhold_e16", b_hold, 4'b0100);
        goto(21); check4("t3_hold_e21", a_hold, 4'b0100); check4("t3_bhold_e21", b_hold, 4'b0000);
        goto(23); btn_raw[2] = 1'b0;
        goto(26); check4("t3_hold_e26", a_hold, 4'b0100);
        goto(30); check4("t3_release_e30", a_release, 4'b0100); check4("t3_hold_e30", a_hold, 4'b0000);
        goto(31); check4("t3_hold_e31", a_hold, 4'b0000);
        goto(36); check4("t3_hold_e36", a_hold, 4'b0000);

        // Long hold: single pulse without repeat, six with repeat
        do_reset(); btn_raw[0] = 1'b1; start();
        nh_a = 0; nh_b = 0; he_b = -1;
        for (int k = 0; k <= 45; k++) begin
            goto(k);
            if (a_hold[0]) nh_a++;
            if (b_hold[0]) begin nh_b++; he_b = k; end
        end
        check_i("t4_norepeat_count", nh_b, 1);
        check_i("t4_norepeat_edge", he_b, 16);
        check_i("t4_repeat_count", nh_a, 6);

        // Simultaneous press on all channels
        do_reset(); btn_raw = 4'b1111; start();
        goto(5); check4("t5_press_e5", a_press, 4'b0000);
        goto(6); check4("t5_press_e6", a_press, 4'b1111); check4("t5_level_e6", a_level, 4'b1111);

        // Reset mid-count on channel 3 while channel 0 is held through it
        do_reset(); btn_raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        check4("t6_pre_level", a_level, 4'b0001);
        btn_raw[3] = 1'b1; start();
        goto(2); rst = 1'b1;
        goto(3); rst = 1'b0;
        check4("t6_reset_level", a_level, 4'b0000);
        goto(9);  check4("t6_level_e9", a_level, 4'b0000);
        goto(10); check4("t6_level_e10", a_level, 4'b1001); check4("t6_press_e10", a_press, 4'b1001);

        // Random bouncing with occasional resets, checked by the scoreboard
        do_reset();
        for (int ch = 0; ch < NB; ch++) seg[ch] = $urandom_range(1, 6);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            for (int ch = 0; ch < NB; ch++) begin
                seg[ch]--;
                if (seg[ch] <= 0) begin
                    btn_raw[ch] = ~btn_raw[ch];
                    seg[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 6);
                end
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_i("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
